mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Parametrised memory-stage unit for the pipelined CPU. Accepts one decoded load/store/ALU-passthrough op per
//  handshake, drives a variable-latency data-memory req/ack port, stalls upstream while waiting, and discards
//  wrong-path instructions using a multi-bit branch epoch in place of the single-bit branch reference toggle.
//  Sits between the execute stage and the writeback stage.
// PARAMETERS
//  DATA_W   32  data bus width
//  ADDR_W   32  memory address width
//  PC_W     7   PC width carried through the pipeline
//  EPOCH_W  2   branch epoch width; 2**EPOCH_W epochs before wrap
//  TIMEOUT  15  max cycles waiting for mem_ack before abort (>=1)
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst          in   1        asynchronous, active-high reset
//  in_valid     in   1        upstream op valid
//  in_ready     out  1        unit can accept op this cycle
//  instr_in     in   32       instruction word
//  pc_in        in   PC_W     PC of instruction
//  epoch_in     in   EPOCH_W  epoch tagged at fetch
//  is_load      in   1        op is LDR
//  is_store     in   1        op is STR (is_load&is_store never both 1)
//  addr_in      in   ADDR_W   effective address from ALU
//  wdata_in     in   DATA_W   store data / ALU result for passthrough
//  branch_taken in   1        1-cycle pulse: branch resolved taken
//  epoch_global out  EPOCH_W  current epoch, for fetch tagging
//  mem_req      out  1        memory request
//  mem_we       out  1        1=write
//  mem_addr     out  ADDR_W   request address
//  mem_wdata    out  DATA_W   write data
//  mem_ack      in   1        request complete; mem_rdata valid same cycle
//  mem_rdata    in   DATA_W   read data
//  out_valid    out  1        result valid to writeback
//  out_ready    in   1        writeback accepts
//  data_out     out  DATA_W   load data, or wdata_in for non-memory ops
//  instr_out    out  32       registered instr_in
//  pc_out       out  PC_W     registered pc_in
//  timeout_err  out  1        sticky: a request timed out
// BEHAVIOUR
//  Reset: state=IDLE; epoch_global=0; mem_req=mem_we=0; out_valid=0; data_out/instr_out/pc_out/mem_addr/mem_wdata=0;
//   timeout_err=0; timer=0. Reset mid-request drops the op; no ack afterwards is consumed.
//  Epoch: branch_taken pulse -> epoch_global+1 mod 2**EPOCH_W next cycle. Op accepted in the cycle of
//   branch_taken is compared against the pre-increment value.
//  in_ready = (state==IDLE) | (state==HOLD & out_ready). Accept = in_valid & in_ready.
//  FSM:
//   IDLE: on accept, latch instr/pc/addr/wdata. If epoch_in!=epoch_global -> squash: stay IDLE, no req,
//    no out_valid. Else if is_load|is_store -> REQ. Else -> HOLD with data_out=wdata_in (1-cycle latency).
//   REQ: mem_req=1, mem_we=is_store, address/data stable until ack. mem_ack -> HOLD, data_out=mem_rdata
//    for load, wdata for store. Ack in first REQ cycle is legal (min load latency 2 cycles accept->out_valid).
//   Timer counts REQ cycles; at TIMEOUT cycles without ack: drop req, set timeout_err, data_out=0 -> HOLD.
//   HOLD: out_valid=1, outputs stable until out_ready. out_ready & in_valid -> back-to-back accept, same
//    IDLE decision applied in this cycle. out_ready & ~in_valid -> IDLE.
//  mem_req never asserted for squashed ops; mem_req deasserts the cycle after ack.
//  Ops already past accept are never squashed by later branch_taken (in-order commit).
//  mem_ack outside REQ is ignored. timeout_err clears only on rst.
// TESTING
//  ALU passthrough: accept wdata_in=32'h1234, out_ready=1 -> out_valid next cycle, data_out=32'h1234, no mem_req.
//  Load, 3-cycle ack: addr=0x40, mem_rdata=0xDEADBEEF -> mem_req 3 cycles, out_valid after, data_out=0xDEADBEEF.
//  Store: is_store, addr=0x10, wdata=0xA5 -> mem_req&mem_we=1, mem_addr=0x10, mem_wdata=0xA5 until ack.
//  Squash: branch_taken pulse, then op with epoch_in=0 while epoch_global=1 -> no mem_req, no out_valid.
//  Epoch wrap: 4 branch_taken pulses, EPOCH_W=2 -> epoch_global 1,2,3,0.
//  Timeout: load, never ack -> mem_req for 15 cycles, then timeout_err=1, out_valid with data_out=0; rst clears.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Execute -> memory stage -> writeback bundle, plus the data-memory req/ack port and epoch broadcast.
interface mem_access_unit_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int PC_W    = 7,
  parameter int EPOCH_W = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        instr_in;
  logic [PC_W-1:0]    pc_in;
  logic [EPOCH_W-1:0] epoch_in;
  logic               is_load;
  logic               is_store;
  logic [ADDR_W-1:0]  addr_in;
  logic [DATA_W-1:0]  wdata_in;
  logic               branch_taken;
  logic [EPOCH_W-1:0] epoch_global;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_ack;
  logic [DATA_W-1:0]  mem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  data_out;
  logic [31:0]        instr_out;
  logic [PC_W-1:0]    pc_out;
  logic               timeout_err;

  modport slave (
    input  in_valid, instr_in, pc_in, epoch_in, is_load, is_store, addr_in, wdata_in,
    input  branch_taken, mem_ack, mem_rdata, out_ready,
    output in_ready, epoch_global, mem_req, mem_we, mem_addr, mem_wdata,
    output out_valid, data_out, instr_out, pc_out, timeout_err
  );

  modport master (
    output in_valid, instr_in, pc_in, epoch_in, is_load, is_store, addr_in, wdata_in,
    output branch_taken, mem_ack, mem_rdata, out_ready,
    input  in_ready, epoch_global, mem_req, mem_we, mem_addr, mem_wdata,
    input  out_valid, data_out, instr_out, pc_out, timeout_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: one op in flight, variable-latency mem req/ack with timeout abort, and epoch-based
// wrong-path squash. Upstream stalls (in_ready low) while a request is pending or a result is unconsumed.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int PC_W    = 7,
  parameter int EPOCH_W = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [EPOCH_W-1:0] r_epoch;
  logic [TMR_W-1:0]   r_timer;
  logic [31:0]        r_instr;
  logic [PC_W-1:0]    r_pc;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_data;
  logic               r_we;
  logic               r_is_load;
  logic               r_timeout_err;

  logic w_in_ready;
  logic w_accept;
  logic w_launch;
  logic w_is_mem;
  logic w_timeout;

  assign w_in_ready = (r_state == S_IDLE) | ((r_state == S_HOLD) & bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  // Compare against the pre-increment epoch so a same-cycle branch does not squash this op.
  assign w_launch   = w_accept & (bus.epoch_in == r_epoch);
  assign w_is_mem   = bus.is_load | bus.is_store;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: if (w_launch) w_state_nxt = w_is_mem ? S_REQ : S_HOLD;
      S_REQ: begin
        if (bus.mem_ack) begin
          w_state_nxt = S_HOLD;
        end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_HOLD;
          w_timeout   = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          if (w_launch) w_state_nxt = w_is_mem ? S_REQ : S_HOLD;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epoch       <= '0;
      r_timer       <= '0;
      r_instr       <= '0;
      r_pc          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_data        <= '0;
      r_we          <= 1'b0;
      r_is_load     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_epoch <= r_epoch + EPOCH_W'(bus.branch_taken);
      if (w_accept) begin
        r_instr   <= bus.instr_in;
        r_pc      <= bus.pc_in;
        r_addr    <= bus.addr_in;
        r_wdata   <= bus.wdata_in;
        r_we      <= bus.is_store;
        r_is_load <= bus.is_load;
      end
      if (w_launch && !w_is_mem) r_data <= bus.wdata_in;
      if (r_state == S_REQ) begin
        if (bus.mem_ack) begin
          r_data <= r_is_load ? bus.mem_rdata : r_wdata;
        end else if (w_timeout) begin
          r_data        <= '0;
          r_timeout_err <= 1'b1;
        end
      end
      if ((r_state == S_REQ) && !bus.mem_ack && !w_timeout) r_timer <= r_timer + 1'b1;
      else                                                  r_timer <= '0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.epoch_global = r_epoch;
  assign bus.mem_req      = (r_state == S_REQ);
  assign bus.mem_we       = (r_state == S_REQ) & r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.out_valid    = (r_state == S_HOLD);
  assign bus.data_out     = r_data;
  assign bus.instr_out    = r_instr;
  assign bus.pc_out       = r_pc;
  assign bus.timeout_err  = r_timeout_err;
endmodule
